// File: rtl/avalon_master_sequencer.sv
// avalon_master_sequencer: single-outstanding Avalon-MM master for a 16x8-bit register slave.
// Optional feature: define AVM_MASTER_READBACK_EN to verify every write with a readback.
module avalon_master_sequencer #(
    parameter int READ_LATENCY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [3:0] cmd_address,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_error,
    output logic [3:0] master_address,
    output logic       master_read,
    output logic       master_write,
    output logic [7:0] master_writedata,
    output logic       master_byteenable,
    input  logic [7:0] master_readdata
);
    localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD = 3'd2, WAIT = 3'd3, RSP = 3'd4;
    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);
    logic [2:0] state;
    logic [3:0] cnt, addr_q;
    logic [7:0] wdata_q;
    logic       write_q, accept;
    assign accept = cmd_valid & cmd_ready;
    // State leads the registered bus/response outputs by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    addr_q  <= cmd_address;
                    wdata_q <= cmd_wdata;
                    write_q <= cmd_write;
                    state   <= cmd_write ? WR : RD;
                end
`ifdef AVM_MASTER_READBACK_EN
                WR: state <= RD;
`else
                WR: state <= RSP;
`endif
                RD: begin
                    cnt   <= LAT_M1;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) state <= RSP;
                end
                RSP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready         <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_rdata         <= '0;
            master_address    <= '0;
            master_read       <= 1'b0;
            master_write      <= 1'b0;
            master_writedata  <= '0;
            master_byteenable <= 1'b0;
`ifdef AVM_MASTER_READBACK_EN
            rsp_error         <= 1'b0;
`endif
        end else begin
            cmd_ready         <= (state == IDLE) && !accept;
            rsp_valid         <= state == RSP;
            master_read       <= state == RD;
            master_write      <= state == WR;
            master_byteenable <= (state == WR) || (state == RD);
            if ((state == WR) || (state == RD)) master_address <= addr_q;
            if (state == WR) master_writedata <= wdata_q;
            // RSP coincides with the cycle the slave presents readdata.
            if (state == RSP) begin
`ifdef AVM_MASTER_READBACK_EN
                rsp_rdata <= master_readdata;
                rsp_error <= write_q && (master_readdata != wdata_q);
`else
                rsp_rdata <= write_q ? 8'd0 : master_readdata;
`endif
            end
        end
    end
`ifndef AVM_MASTER_READBACK_EN
    assign rsp_error = 1'b0;
`endif
endmodule
